// File: rtl/dec_trigger_ctl.sv
// rtl/dec_trigger_ctl.sv - debug trigger registers, chain/slot qualification and TLU request sequencing
package dec_trigger_pkg;
  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        execute;
    logic        m;
    logic [31:0] tdata2;
  } trigger_pkt_t;
endpackage

module dec_trigger_ctl
  import dec_trigger_pkg::*;
#(
  parameter int NUM_TRIG = 4
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       csr_wr_valid,
  input  logic [1:0]                 csr_wr_sel,
  input  logic                       csr_wr_tdata2,
  input  logic [31:0]                csr_wr_data,
  input  logic [1:0]                 csr_rd_sel,
  input  logic                       csr_rd_tdata2,
  output logic [31:0]                csr_rd_data,
  input  logic                       dbg_mode,
  output trigger_pkt_t [NUM_TRIG-1:0] trigger_pkt_any,
  input  logic [NUM_TRIG-1:0]        dec_i0_trigger_match_d,
  input  logic [NUM_TRIG-1:0]        dec_i1_trigger_match_d,
  input  logic                       dec_i0_valid_d,
  input  logic                       dec_i1_valid_d,
  input  logic                       dec_flush,
  output logic                       trig_exc_req,
  output logic                       trig_halt_req,
  output logic                       trig_slot,
  output logic [NUM_TRIG-1:0]        trig_fire_vec,
  input  logic                       trig_ack
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [NUM_TRIG-1:0] dmode_q, dmode_d;
  logic [NUM_TRIG-1:0] hit_q, hit_d;
  logic [NUM_TRIG-1:0] select_q, select_d;
  logic [NUM_TRIG-1:0] action_q, action_d;
  logic [NUM_TRIG-1:0] chain_q, chain_d;
  logic [NUM_TRIG-1:0] match_q, match_d;
  logic [NUM_TRIG-1:0] m_q, m_d;
  logic [NUM_TRIG-1:0] exec_q, exec_d;
  logic [31:0]         tdata2_q [NUM_TRIG];
  logic [31:0]         tdata2_d [NUM_TRIG];

  logic [NUM_TRIG-1:0] fire_q, fire_d;
  logic                slot_q, slot_d;
  logic                halt_q, halt_d;
  logic [31:0]         rd_q, rd_d;

  logic                wr_en;
  logic                hit_set;
  logic [NUM_TRIG-1:0] raw_i0, raw_i1;
  logic [NUM_TRIG-1:0] qual_i0, qual_i1;
  logic [NUM_TRIG-1:0] fire_sel;
  logic                slot_sel;
  logic [31:0]         tdata1_rd [NUM_TRIG];

  // A chained pair only survives when both members hit in the same slot.
  function automatic logic [3:0] chain_qual(input logic [3:0] raw, input logic c01, input logic c23);
    logic [3:0] q;
    q = raw;
    if (c01) q[1:0] = {2{&raw[1:0]}};
    if (c23) q[3:2] = {2{&raw[3:2]}};
    return q;
  endfunction

  always_comb begin
    raw_i0   = {NUM_TRIG{dec_i0_valid_d & ~dbg_mode}} & dec_i0_trigger_match_d & exec_q;
    raw_i1   = {NUM_TRIG{dec_i1_valid_d & ~dbg_mode}} & dec_i1_trigger_match_d & exec_q;
    qual_i0  = chain_qual(raw_i0, chain_q[0], chain_q[2]);
    qual_i1  = chain_qual(raw_i1, chain_q[0], chain_q[2]);
    slot_sel = ~(|qual_i0);
    fire_sel = slot_sel ? qual_i1 : qual_i0;
  end

  always_comb begin
    state_d = state_q;
    fire_d  = fire_q;
    slot_d  = slot_q;
    halt_d  = halt_q;
    hit_set = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|fire_sel) && !dec_flush) begin
          fire_d  = fire_sel;
          slot_d  = slot_sel;
          halt_d  = |(fire_sel & action_q);
          state_d = PEND;
        end
      end
      PEND: begin
        if (trig_ack) begin
          hit_set = 1'b1;
          fire_d  = '0;
          slot_d  = 1'b0;
          halt_d  = 1'b0;
          state_d = IDLE;
        end else if (dec_flush) begin
          fire_d  = '0;
          slot_d  = 1'b0;
          halt_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A trigger owned by debug mode is frozen against writes from normal mode.
  assign wr_en = csr_wr_valid & ~(dmode_q[csr_wr_sel] & ~dbg_mode);

  always_comb begin
    dmode_d  = dmode_q;
    hit_d    = hit_q;
    select_d = select_q;
    action_d = action_q;
    chain_d  = chain_q;
    match_d  = match_q;
    m_d      = m_q;
    exec_d   = exec_q;
    tdata2_d = tdata2_q;
    if (wr_en) begin
      if (csr_wr_tdata2) begin
        tdata2_d[csr_wr_sel] = csr_wr_data;
      end else begin
        if (dbg_mode) dmode_d[csr_wr_sel] = csr_wr_data[27];
        hit_d[csr_wr_sel]    = csr_wr_data[20];
        select_d[csr_wr_sel] = csr_wr_data[19];
        action_d[csr_wr_sel] = csr_wr_data[12];
        chain_d[csr_wr_sel]  = csr_wr_data[11] & ~csr_wr_sel[0];
        match_d[csr_wr_sel]  = csr_wr_data[7];
        m_d[csr_wr_sel]      = csr_wr_data[6];
        exec_d[csr_wr_sel]   = csr_wr_data[2];
      end
    end
    if (hit_set) hit_d = hit_d | fire_q;
  end

  always_comb begin
    for (int i = 0; i < NUM_TRIG; i++) begin
      tdata1_rd[i]     = '0;
      tdata1_rd[i][27] = dmode_q[i];
      tdata1_rd[i][20] = hit_q[i];
      tdata1_rd[i][19] = select_q[i];
      tdata1_rd[i][12] = action_q[i];
      tdata1_rd[i][11] = chain_q[i];
      tdata1_rd[i][7]  = match_q[i];
      tdata1_rd[i][6]  = m_q[i];
      tdata1_rd[i][2]  = exec_q[i];
    end
    rd_d = csr_rd_tdata2 ? tdata2_q[csr_rd_sel] : tdata1_rd[csr_rd_sel];
  end

  always_comb begin
    for (int i = 0; i < NUM_TRIG; i++) begin
      trigger_pkt_any[i].select  = select_q[i];
      trigger_pkt_any[i].match   = match_q[i];
      trigger_pkt_any[i].store   = 1'b0;
      trigger_pkt_any[i].load    = 1'b0;
      trigger_pkt_any[i].execute = exec_q[i];
      trigger_pkt_any[i].m       = m_q[i];
      trigger_pkt_any[i].tdata2  = tdata2_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      dmode_q  <= '0;
      hit_q    <= '0;
      select_q <= '0;
      action_q <= '0;
      chain_q  <= '0;
      match_q  <= '0;
      m_q      <= '0;
      exec_q   <= '0;
      for (int i = 0; i < NUM_TRIG; i++) tdata2_q[i] <= '0;
      fire_q   <= '0;
      slot_q   <= 1'b0;
      halt_q   <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      dmode_q  <= dmode_d;
      hit_q    <= hit_d;
      select_q <= select_d;
      action_q <= action_d;
      chain_q  <= chain_d;
      match_q  <= match_d;
      m_q      <= m_d;
      exec_q   <= exec_d;
      tdata2_q <= tdata2_d;
      fire_q   <= fire_d;
      slot_q   <= slot_d;
      halt_q   <= halt_d;
      rd_q     <= rd_d;
    end
  end

  assign trig_exc_req  = (state_q == PEND) & ~halt_q;
  assign trig_halt_req = (state_q == PEND) & halt_q;
  assign trig_slot     = slot_q;
  assign trig_fire_vec = fire_q;
  assign csr_rd_data   = rd_q;

endmodule

// File: tb/tb_dec_trigger_ctl.sv
// tb/tb_dec_trigger_ctl.sv - self-checking bench for dec_trigger_ctl
module tb_dec_trigger_ctl;
  import dec_trigger_pkg::*;

  logic clk = 1'b0;
  logic rst_l;
  logic csr_wr_valid, csr_wr_tdata2, csr_rd_tdata2, dbg_mode;
  logic [1:0] csr_wr_sel, csr_rd_sel;
  logic [31:0] csr_wr_data, csr_rd_data;
  trigger_pkt_t [3:0] trigger_pkt_any;
  logic [3:0] dec_i0_trigger_match_d, dec_i1_trigger_match_d, trig_fire_vec;
  logic dec_i0_valid_d, dec_i1_valid_d, dec_flush, trig_ack;
  logic trig_exc_req, trig_halt_req, trig_slot;

  always #5 clk = ~clk;

  dec_trigger_ctl dut (
    .clk(clk), .rst_l(rst_l),
    .csr_wr_valid(csr_wr_valid), .csr_wr_sel(csr_wr_sel), .csr_wr_tdata2(csr_wr_tdata2),
    .csr_wr_data(csr_wr_data), .csr_rd_sel(csr_rd_sel), .csr_rd_tdata2(csr_rd_tdata2),
    .csr_rd_data(csr_rd_data), .dbg_mode(dbg_mode), .trigger_pkt_any(trigger_pkt_any),
    .dec_i0_trigger_match_d(dec_i0_trigger_match_d), .dec_i1_trigger_match_d(dec_i1_trigger_match_d),
    .dec_i0_valid_d(dec_i0_valid_d), .dec_i1_valid_d(dec_i1_valid_d), .dec_flush(dec_flush),
    .trig_exc_req(trig_exc_req), .trig_halt_req(trig_halt_req), .trig_slot(trig_slot),
    .trig_fire_vec(trig_fire_vec), .trig_ack(trig_ack)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: tdata1 kept as the architectural 32-bit word.
  localparam logic [31:0] T1_MASK = 32'h0018_10C4;
  localparam logic [31:0] B_DMODE = 32'h0800_0000;
  localparam logic [31:0] B_CHAIN = 32'h0000_0800;
  localparam logic [31:0] B_HIT   = 32'h0010_0000;

  logic [31:0] m_t1 [4];
  logic [31:0] m_t2 [4];
  logic        m_pend, m_slot, m_halt;
  logic [3:0]  m_fire;
  logic [31:0] m_rd;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_t1[i] = 0; m_t2[i] = 0; end
    m_pend = 0; m_slot = 0; m_halt = 0; m_fire = 0; m_rd = 0;
  endtask

  function automatic logic [3:0] hits(input logic v, input logic [3:0] mv);
    logic [3:0] q;
    for (int i = 0; i < 4; i++) q[i] = v && !dbg_mode && mv[i] && m_t1[i][2];
    for (int p = 0; p < 4; p += 2)
      if (m_t1[p][11] && !(q[p] && q[p+1])) begin q[p] = 0; q[p+1] = 0; end
    return q;
  endfunction

  task automatic model_step();
    logic [3:0] q0, q1, fire, hs;
    logic halt;
    m_rd = csr_rd_tdata2 ? m_t2[csr_rd_sel] : m_t1[csr_rd_sel];
    q0 = hits(dec_i0_valid_d, dec_i0_trigger_match_d);
    q1 = hits(dec_i1_valid_d, dec_i1_trigger_match_d);
    fire = (q0 != 0) ? q0 : q1;
    halt = 0;
    for (int i = 0; i < 4; i++) if (fire[i] && m_t1[i][12]) halt = 1;
    hs = (m_pend && trig_ack) ? m_fire : 4'b0;
    if (csr_wr_valid && !(m_t1[csr_wr_sel][27] && !dbg_mode)) begin
      if (csr_wr_tdata2) m_t2[csr_wr_sel] = csr_wr_data;
      else m_t1[csr_wr_sel] = (csr_wr_data & T1_MASK)
                              | (csr_wr_sel[0] ? 32'h0 : (csr_wr_data & B_CHAIN))
                              | (dbg_mode ? (csr_wr_data & B_DMODE) : (m_t1[csr_wr_sel] & B_DMODE));
    end
    for (int i = 0; i < 4; i++) if (hs[i]) m_t1[i] = m_t1[i] | B_HIT;
    if (!m_pend) begin
      if (fire != 0 && !dec_flush) begin
        m_pend = 1; m_fire = fire; m_slot = (q0 == 0); m_halt = halt;
      end
    end else if (trig_ack || dec_flush) begin
      m_pend = 0; m_fire = 0; m_slot = 0; m_halt = 0;
    end
  endtask

  function automatic logic [6:0] outs();
    return {trig_exc_req, trig_halt_req, trig_slot, trig_fire_vec};
  endfunction

  task automatic clear_inputs();
    csr_wr_valid = 0; csr_wr_sel = 0; csr_wr_tdata2 = 0; csr_wr_data = 0;
    csr_rd_sel = 0; csr_rd_tdata2 = 0;
    dec_i0_trigger_match_d = 0; dec_i1_trigger_match_d = 0;
    dec_i0_valid_d = 0; dec_i1_valid_d = 0; dec_flush = 0; trig_ack = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_l = 0;
    @(posedge clk);
    #1;
    rst_l = 1;
    model_reset();
  endtask

  task automatic wr(input logic [1:0] s, input logic t2, input logic [31:0] d);
    csr_wr_valid = 1; csr_wr_sel = s; csr_wr_tdata2 = t2; csr_wr_data = d;
    cycle();
    csr_wr_valid = 0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] s, input logic t2, input logic [31:0] exp);
    csr_rd_sel = s; csr_rd_tdata2 = t2;
    cycle();
    check(name, csr_rd_data, exp);
  endtask

  task automatic fire_i0(input logic [3:0] mv);
    dec_i0_valid_d = 1; dec_i0_trigger_match_d = mv;
    cycle();
    dec_i0_valid_d = 0; dec_i0_trigger_match_d = 0;
  endtask

  typedef struct {
    logic wr; logic [1:0] wsel; logic wt2; logic [31:0] wdata;
    logic v0; logic [3:0] m0; logic v1; logic [3:0] m1; logic ack;
    logic chk; logic [1:0] rsel; logic rt2; logic [31:0] exp_rd;
    logic [6:0] exp_out;
  } vec_t;

  function automatic vec_t row(input logic wr, input logic [1:0] wsel, input logic wt2, input logic [31:0] wdata,
                               input logic v0, input logic [3:0] m0, input logic v1, input logic [3:0] m1,
                               input logic ack, input logic chk, input logic [1:0] rsel, input logic rt2,
                               input logic [31:0] exp_rd, input logic [6:0] exp_out);
    vec_t r;
    r.wr = wr; r.wsel = wsel; r.wt2 = wt2; r.wdata = wdata;
    r.v0 = v0; r.m0 = m0; r.v1 = v1; r.m1 = m1; r.ack = ack;
    r.chk = chk; r.rsel = rsel; r.rt2 = rt2; r.exp_rd = exp_rd; r.exp_out = exp_out;
    return r;
  endfunction

  vec_t tbl [18];

  initial begin
    // out = {exc, halt, slot, fire[3:0]}
    tbl[0]  = row(1, 1, 1, 32'h1000, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0,      7'b0000000);
    tbl[1]  = row(1, 1, 0, 32'h44,   0, 0, 0, 0, 0, 1, 1, 1, 32'h1000,   7'b0000000);
    tbl[2]  = row(0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 1, 1, 0, 32'h44,     7'b1000010);
    tbl[3]  = row(0, 0, 0, 0, 0, 0, 0, 0, 1,       1, 1, 0, 32'h44,     7'b0000000);
    tbl[4]  = row(0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 1, 0, 32'h100044, 7'b0000000);
    tbl[5]  = row(1, 0, 0, 32'h844,  0, 0, 0, 0, 0, 1, 0, 0, 32'h0,      7'b0000000);
    tbl[6]  = row(0, 0, 0, 0, 1, 4'b0001, 0, 0, 0, 1, 0, 0, 32'h844,    7'b0000000);
    tbl[7]  = row(0, 0, 0, 0, 1, 4'b0011, 0, 0, 0, 0, 0, 0, 32'h0,      7'b1000011);
    tbl[8]  = row(0, 0, 0, 0, 0, 0, 0, 0, 1,       0, 0, 0, 32'h0,      7'b0000000);
    tbl[9]  = row(1, 2, 0, 32'h1044, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,      7'b0000000);
    tbl[10] = row(1, 3, 0, 32'h44,   0, 0, 0, 0, 0, 1, 0, 0, 32'h100844, 7'b0000000);
    tbl[11] = row(0, 0, 0, 0, 1, 4'b0100, 1, 4'b1000, 0, 0, 0, 0, 32'h0, 7'b0100100);
    tbl[12] = row(0, 0, 0, 0, 0, 0, 0, 0, 1,       0, 0, 0, 32'h0,      7'b0000000);
    tbl[13] = row(0, 0, 0, 0, 0, 4'b0100, 1, 4'b1000, 0, 1, 2, 0, 32'h101044, 7'b1011000);
    tbl[14] = row(0, 0, 0, 0, 0, 0, 0, 0, 1,       0, 0, 0, 32'h0,      7'b0000000);
    tbl[15] = row(0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 3, 0, 32'h100044, 7'b0000000);
    tbl[16] = row(1, 1, 0, 32'h844,  0, 0, 0, 0, 0, 0, 0, 0, 32'h0,      7'b0000000);
    tbl[17] = row(0, 0, 0, 0, 0, 0, 0, 0, 0,       1, 1, 0, 32'h44,     7'b0000000);
  end

  initial begin
    dbg_mode = 0;
    do_reset();
    check("reset_outs", outs(), 7'b0);
    check("reset_rd", csr_rd_data, 32'h0);

    for (int r = 0; r < 18; r++) begin
      csr_wr_valid = tbl[r].wr; csr_wr_sel = tbl[r].wsel; csr_wr_tdata2 = tbl[r].wt2; csr_wr_data = tbl[r].wdata;
      dec_i0_valid_d = tbl[r].v0; dec_i0_trigger_match_d = tbl[r].m0;
      dec_i1_valid_d = tbl[r].v1; dec_i1_trigger_match_d = tbl[r].m1;
      trig_ack = tbl[r].ack; csr_rd_sel = tbl[r].rsel; csr_rd_tdata2 = tbl[r].rt2;
      cycle();
      check($sformatf("tbl%0d_outs", r), outs(), tbl[r].exp_out);
      if (tbl[r].chk) check($sformatf("tbl%0d_rd", r), csr_rd_data, tbl[r].exp_rd);
    end
    clear_inputs();

    // flush without ack, then flush together with ack
    do_reset();
    wr(1, 0, 32'h44);
    fire_i0(4'b0010);
    check("flush_pend", outs(), 7'b1000010);
    dec_flush = 1; cycle(); dec_flush = 0;
    check("flush_clear", outs(), 7'b0);
    rd_chk("flush_nohit", 1, 0, 32'h44);
    fire_i0(4'b0010);
    dec_flush = 1; trig_ack = 1; cycle(); dec_flush = 0; trig_ack = 0;
    check("flush_ack_clear", outs(), 7'b0);
    rd_chk("flush_ack_hit", 1, 0, 32'h100044);

    // dmode ownership lock
    do_reset();
    dbg_mode = 1;
    wr(2, 1, 32'h1234);
    wr(2, 0, 32'h0800_0044);
    dbg_mode = 0;
    wr(2, 1, 32'hFFFF_FFFF);
    rd_chk("lock_t2", 2, 1, 32'h1234);
    wr(2, 0, 32'h0);
    rd_chk("lock_t1", 2, 0, 32'h0800_0044);
    wr(0, 0, 32'h0800_0044);
    rd_chk("dmode_nodbg", 0, 0, 32'h44);
    dbg_mode = 1;
    dec_i0_valid_d = 1; dec_i0_trigger_match_d = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("dbg_nofire%0d", k), outs(), 7'b0);
    end
    dbg_mode = 0;
    cycle();
    check("nodbg_fire", outs(), 7'b1000100);
    clear_inputs();
    trig_ack = 1; cycle(); trig_ack = 0;

    // ack in IDLE, then hit set colliding with a tdata1 write
    do_reset();
    wr(1, 0, 32'h44);
    trig_ack = 1; cycle(); trig_ack = 0;
    rd_chk("ack_idle", 1, 0, 32'h44);
    fire_i0(4'b0010);
    trig_ack = 1; wr(1, 0, 32'h1044); trig_ack = 0;
    rd_chk("hit_vs_wr", 1, 0, 32'h101044);

    // asynchronous reset while a request is pending
    do_reset();
    wr(1, 0, 32'h44);
    wr(1, 1, 32'hABCD);
    fire_i0(4'b0010);
    check("pre_rst_pend", outs(), 7'b1000010);
    #2 rst_l = 0;
    #1 check("async_rst_outs", outs(), 7'b0);
    @(posedge clk);
    #1 rst_l = 1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      rd_chk($sformatf("rst_t1_%0d", i), i[1:0], 0, 32'h0);
      rd_chk($sformatf("rst_t2_%0d", i), i[1:0], 1, 32'h0);
    end

    // randomized run against the reference model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      csr_wr_valid = ($urandom_range(0, 9) < 3);
      csr_wr_sel = 2'($urandom);
      csr_wr_tdata2 = $urandom_range(0, 1);
      csr_wr_data = $urandom;
      dbg_mode = ($urandom_range(0, 19) == 0);
      dec_i0_valid_d = ($urandom_range(0, 9) < 7);
      dec_i1_valid_d = ($urandom_range(0, 9) < 7);
      dec_i0_trigger_match_d = 4'($urandom);
      dec_i1_trigger_match_d = 4'($urandom);
      dec_flush = ($urandom_range(0, 9) == 0);
      trig_ack = ($urandom_range(0, 9) < 3);
      csr_rd_sel = 2'($urandom);
      csr_rd_tdata2 = $urandom_range(0, 1);
      cycle();
      check($sformatf("rnd%0d_outs", c), outs(), {m_pend & ~m_halt, m_pend & m_halt, m_slot, m_fire});
      check($sformatf("rnd%0d_rd", c), csr_rd_data, m_rd);
      for (int i = 0; i < 4; i++)
        check($sformatf("rnd%0d_pkt%0d", c, i),
              {trigger_pkt_any[i].select, trigger_pkt_any[i].match, trigger_pkt_any[i].execute,
               trigger_pkt_any[i].m, trigger_pkt_any[i].tdata2},
              {m_t1[i][19], m_t1[i][7], m_t1[i][2], m_t1[i][6], m_t2[i]});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dec_trigger_ctl.md
Name: dec_trigger_ctl

Overview:
- Debug-trigger control block in DEC, paired with the per-trigger PC matcher.
- Holds the four trigger register sets (tdata1 fields and tdata2), written through a CSR-style port, and drives the trigger_pkt_any bundle that feeds the matchers.
- Takes the per-slot i0/i1 match vectors back from the matchers, applies chaining and slot priority, and sequences the resulting breakpoint-exception or debug-halt request to the TLU through a request/acknowledge handshake.

Parameters:
NUM_TRIG, 4, number of triggers; fixed at 4 (chain pairs 0-1, 2-3).

Ports:
clk  input  1  core clock
rst_l  input  1  asynchronous active-low reset
csr_wr_valid  input  1  trigger CSR write strobe
csr_wr_sel  input  2  target trigger index (tselect)
csr_wr_tdata2  input  1  1: write tdata2; 0: write tdata1
csr_wr_data  input  32  write data
csr_rd_sel  input  2  read trigger index
csr_rd_tdata2  input  1  read tdata2 when 1, else tdata1
csr_rd_data  output  32  registered read data
dbg_mode  input  1  core in debug mode
trigger_pkt_any  output  trigger_pkt_t[3:0]  config to matchers
dec_i0_trigger_match_d  input  4  i0 per-trigger match
dec_i1_trigger_match_d  input  4  i1 per-trigger match
dec_i0_valid_d  input  1  i0 valid in decode
dec_i1_valid_d  input  1  i1 valid in decode
dec_flush  input  1  kill staged and pending hits
trig_exc_req  output  1  breakpoint exception request
trig_halt_req  output  1  debug halt request
trig_slot  output  1  0: i0 caused hit; 1: i1 caused hit
trig_fire_vec  output  4  triggers firing for the pending request
trig_ack  input  1  TLU accepts the request

Behaviour:
- Reset: all register fields 0; FSM IDLE; csr_rd_data, trig_exc_req, trig_halt_req, trig_slot, trig_fire_vec all 0.
- tdata1 layout:
  - [27] dmode, [20] hit, [12] action (0 = exception, 1 = halt), [11] chain, [7] match, [6] m, [2] execute, [19] select.
  - All other bits read 0.
- Chain bit:
  - Writable only for triggers 0 and 2.
  - Reads 0 for triggers 1 and 3.
- Write lock: a write to a trigger with dmode = 1 is ignored when dbg_mode = 0. dmode itself is writable only when dbg_mode = 1.
- Write timing:
  - A write takes effect the cycle after csr_wr_valid.
  - trigger_pkt_any reflects the new value in that same following cycle.
- csr_rd_data is registered: one-cycle latency from csr_rd_sel / csr_rd_tdata2.
- Raw fire (combinational) for trigger i in slot s: slot valid & match_s[i] & execute[i] & ~dbg_mode.
- Chain qualification:
  - If chain[0] = 1, triggers 0 and 1 fire only if both match the same slot; both bits are then set.
  - Triggers 2 and 3 behave the same under chain[2].
- Slot priority: i0 wins. i1 is considered only if i0 has no qualified fire.
- Stage register:
  - In IDLE with a qualified fire and no dec_flush, capture fire_vec, slot and halt. halt = OR of action over the firing triggers.
  - Go to PEND next cycle.
- PEND:
  - trig_halt_req = halt, trig_exc_req = ~halt (one-hot).
  - trig_fire_vec and trig_slot are held stable.
  - New matches are ignored.
- Acknowledge: trig_ack in PEND sets hit[i] for every bit in trig_fire_vec, clears the request outputs and returns to IDLE next cycle.
  - A match in the ack cycle is ignored; matches are sampled again from the following cycle.
- Flush:
  - dec_flush in PEND without trig_ack returns to IDLE, clears outputs, and sets no hit bits.
  - dec_flush together with trig_ack: the ack wins and hit bits are set.
- CSR write vs. hit set on the same trigger in the same cycle: the hit set wins for the hit bit; all other fields take the write data.
- trig_ack in IDLE is ignored.
- Reset asserted mid-PEND: everything returns to reset values immediately (asynchronous).

Test Plan:
- Trigger 1: write tdata2 = 0x0000_1000, tdata1 execute = 1, m = 1, action = 0; drive i0 match = 4'b0010 with valid -> next cycle trig_exc_req = 1, trig_fire_vec = 4'b0010, trig_slot = 0. Ack -> tdata1 read returns hit = 1 (bit 20).
- Chain 0-1 with chain[0] = 1: i0 match = 4'b0001 -> no request. i0 match = 4'b0011 -> request with trig_fire_vec = 4'b0011.
- Same cycle i0 match = 4'b0100 (action = 1) and i1 match = 4'b1000 -> trig_halt_req = 1, trig_slot = 0, trig_fire_vec = 4'b0100.
- Request pending, assert dec_flush with no ack -> outputs 0 next cycle, hit bits remain 0. Repeat with flush and ack in the same cycle -> hit bits set.
- dmode = 1 on trigger 2 (written in debug mode), then dbg_mode = 0 and write tdata2 = 0xFFFF_FFFF -> read back shows the old value. With dbg_mode = 1, matches produce no request.
- Deassert rst_l during PEND -> trig_exc_req drops immediately; all register fields read 0 after reset release.
